// File: rtl/pc_fetch_pkg.sv
// Shared constants and the fetch-state encoding for the PC/fetch stage.
package pc_fetch_pkg;
  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {F_BOOT, F_RUN, F_HOLD} fetch_state_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch request channel (valid/ready, address).
interface pc_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;

  modport master (output imem_req_valid, output imem_addr, input imem_req_ready);
  modport slave  (input imem_req_valid, input imem_addr, output imem_req_ready);
endinterface

// File: rtl/pc_target_sel.sv
// Redirect target select: jalr vs branch, low-bit clearing, misalignment flag.
// Macro PC_MISALIGN_TRAP_EN: flag misaligned targets instead of forcing alignment.
module pc_target_sel #(
  parameter int XLEN = pc_fetch_pkg::XLEN
) (
  input  logic            jalr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] tgt,
  output logic            misaligned
);
  import pc_fetch_pkg::*;

  localparam logic [XLEN-1:0] BIT0 = XLEN'(1);
  localparam logic [XLEN-1:0] BIT1 = XLEN'(2);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = jalr ? (jalr_target & ~BIT0) : branch_target;
`ifdef PC_MISALIGN_TRAP_EN
    tgt        = raw;
    misaligned = |raw[1:0];
`else
    // without the trap, targets are silently word-aligned on bit 1
    tgt        = raw & ~BIT1;
    misaligned = 1'b0;
`endif
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Next-PC / fetch-request stage: PC register, imem handshake, pending redirect, flush.
// Macro PC_MISALIGN_TRAP_EN: drop misaligned redirects and pulse misalign_trap.
module pc_fetch_unit #(
  parameter int              XLEN     = pc_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pc_fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_source,
  input  logic            jalr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            redirect_valid,
  input  logic            stall,
  pc_fetch_unit_if.master imem,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            misalign_trap
);
  import pc_fetch_pkg::*;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] tgt, next_pc, pend_target;
  logic            misaligned, take, take_eff, adv, pend_valid, flush_q;

  pc_target_sel #(.XLEN(XLEN)) u_tsel (
    .jalr          (jalr),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .tgt           (tgt),
    .misaligned    (misaligned)
  );

  assign take     = redirect_valid & pc_source;
  assign take_eff = take & ~misaligned;
  assign adv      = (state != F_BOOT) & imem.imem_req_ready & ~stall;
  assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
  assign imem.imem_addr = pc;
  assign flush    = flush_q | pend_valid;

  always_comb begin
    if (take_eff)        next_pc = tgt;
    else if (pend_valid) next_pc = pend_target;
    else                 next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= F_BOOT;
    else     state <= state_n;
  end

  always_comb begin
    state_n             = state;
    imem.imem_req_valid = 1'b0;
    case (state)
      F_BOOT: state_n = F_RUN;
      F_RUN, F_HOLD: begin
        imem.imem_req_valid = 1'b1;
        state_n             = adv ? F_RUN : F_HOLD;
      end
      default: state_n = F_BOOT;
    endcase
  end

  // A redirect that cannot be taken now is parked; a later one overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      flush_q     <= 1'b0;
    end else begin
      flush_q <= take_eff;
      if (adv) begin
        pc         <= next_pc;
        pend_valid <= 1'b0;
      end else if (take_eff) begin
        pend_valid  <= 1'b1;
        pend_target <= tgt;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= take & misaligned;
  end
  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus random checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, pc_source, jalr, redirect_valid, stall;
  logic [31:0] branch_target, jalr_target, pc, pc_plus4;
  logic        flush, misalign_trap;
  int          errs = 0, checks = 0;

  // model: fetch is live after the first post-reset edge; one parked redirect at most
  logic [31:0] m_pc, m_pt;
  logic        m_live, m_pv, m_fl, m_trap;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(32)) imem ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_source(pc_source), .jalr(jalr),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .redirect_valid(redirect_valid), .stall(stall), .imem(imem),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .misalign_trap(misalign_trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] t;
    logic        take, mis, accept;
    if (rst) begin
      m_pc = 32'h0; m_pv = 0; m_pt = 0; m_live = 0; m_fl = 0; m_trap = 0;
      return;
    end
    take = redirect_valid & pc_source;
    t    = jalr ? {jalr_target[31:1], 1'b0} : branch_target;
`ifdef PC_MISALIGN_TRAP_EN
    mis = (t[1:0] != 2'b00);
`else
    t[1] = 1'b0;
    mis  = 1'b0;
`endif
    m_trap = take & mis;
    take   = take & ~mis;
    accept = m_live & imem.imem_req_ready & ~stall;
    if (accept) begin
      m_pc = take ? t : (m_pv ? m_pt : m_pc + 32'd4);
      m_pv = 0;
    end else if (take) begin
      m_pv = 1; m_pt = t;
    end
    m_fl   = take;
    m_live = 1;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk); #1;
    chk("req_valid", imem.imem_req_valid, m_live);
    chk("imem_addr", imem.imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("flush", flush, m_fl | m_pv);
    chk("misalign_trap", misalign_trap, m_trap);
  endtask

  task automatic drive(input logic tk, input logic j, input logic [31:0] bt,
                       input logic [31:0] jt, input logic rdy, input logic st);
    redirect_valid = tk; pc_source = tk; jalr = j;
    branch_target = bt; jalr_target = jt;
    imem.imem_req_ready = rdy; stall = st;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    cycle(); cycle();
    chk("rst_valid", imem.imem_req_valid, 0);
    rst = 1'b0;
    cycle();
    chk("boot_addr", imem.imem_addr, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk("seq_addr", imem.imem_addr, 32'(i * 4));
    end
    // back-pressure at 0x20
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_addr", imem.imem_addr, 32'h20);
      chk("hold_state", 32'(dut.state), 32'(pc_fetch_pkg::F_HOLD));
    end
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("hold_release", imem.imem_addr, 32'h24);
    // immediate branch from 0x40
    drive(1, 0, 32'h40, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);      cycle();
    drive(1, 0, 32'h100, 0, 1, 0); cycle();
    chk("br_addr", imem.imem_addr, 32'h100);
    chk("br_flush", flush, 1);
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("br_flush_drop", flush, 0);
    // parked jalr redirect
    drive(1, 0, 32'h40, 0, 1, 0);  cycle();
    drive(1, 1, 0, 32'h203, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);       cycle();
    chk("pend_flush", flush, 1);
    chk("pend_target", dut.pend_target, 32'h200);
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("pend_load", imem.imem_addr, 32'h200);
    chk("pend_flush_drop", flush, 0);
    // wrap at top of address space
    drive(1, 0, 32'hFFFF_FFFC, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("wrap_addr", imem.imem_addr, 32'h0);
    // misaligned branch target
    drive(1, 0, 32'h102, 0, 1, 0); cycle();
`ifndef PC_MISALIGN_TRAP_EN
    chk("align_addr", imem.imem_addr, 32'h100);
`endif
    // reset while a redirect is parked
    drive(1, 0, 32'h300, 0, 0, 0); cycle();
    rst = 1'b1; drive(0, 0, 0, 0, 1, 0); cycle();
    chk("rst_pend", dut.pend_valid, 0);
    chk("rst_pc", pc, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < 20), $urandom_range(1),
            $urandom & 32'hFFFF_FFFE, $urandom,
            ($urandom_range(99) < 70), ($urandom_range(99) < 20));
      rst = ($urandom_range(199) == 0);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Next-PC and fetch-request stage.
- Consumes the taken/not-taken decision (pc_source) and target addresses from the branch decision logic.
- Owns the architectural PC register and presents fetch addresses to instruction memory over a valid/ready handshake.
- Buffers a redirect that arrives while a fetch cannot advance, and drives a flush to the IF/ID stage.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- pc_source  in  1  redirect request from the branch decision logic (branch taken, jal, or jalr).
- jalr  in  1  1 = target comes from jalr_target; 0 = target comes from branch_target.
- branch_target  in  XLEN  PC+imm computed in EX.
- jalr_target  in  XLEN  rs1+imm; bit 0 is cleared internally.
- redirect_valid  in  1  EX holds a valid instruction; qualifies pc_source.
- stall  in  1  hazard-unit hold; PC must not advance.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_addr  out  XLEN  fetch address (equals pc).
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc+4, for the jal/jalr link value.
- flush  out  1  squash the IF/ID instruction.
- misalign_trap  out  1  misaligned-target trap pulse; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, imem_req_valid=0, flush=0, misalign_trap=0.
  - pend_valid=0, pend_target=0, state=F_BOOT.
  - Applies identically mid-operation: any pending redirect and any outstanding request are dropped.
- States:
  - F_BOOT: imem_req_valid=0. Next state is F_RUN unconditionally on the first edge with rst=0.
  - F_RUN: imem_req_valid=1, imem_addr=pc.
    - adv = imem_req_ready & ~stall.
    - If adv, pc <= next_pc and state stays F_RUN.
    - If ~adv, state goes to F_HOLD.
  - F_HOLD: imem_req_valid=1 and imem_addr held stable.
    - Returns to F_RUN and loads next_pc on the first cycle with adv=1.
- Handshake: imem_addr must not change while imem_req_valid=1 & imem_req_ready=0. A request accepted during stall=1 does not advance pc, so the same address is re-requested.
- take = redirect_valid & pc_source.
- tgt:
  - jalr=1: {jalr_target[XLEN-1:1],1'b0}.
  - jalr=0: branch_target.
- next_pc priority:
  1. take -> tgt.
  2. pend_valid -> pend_target.
  3. otherwise pc+4.
  - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Redirect while ~adv: pend_target <= tgt, pend_valid <= 1.
  - A second take while pend_valid is set overwrites pend_target.
  - pend_valid clears on the edge where pc loads pend_target.
  - take & adv in the same cycle loads tgt directly and never sets pend_valid.
- flush = registered(take) | pend_valid.
  - Goes high the cycle after take and stays high until the cycle after the target is loaded into pc.
  - Exactly one cycle high when the redirect is taken immediately.
- pc_plus4 is combinational from pc.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - If take and tgt[1:0]!=2'b00, the redirect is ignored: pc follows the normal pc+4/pending path and pend_target is unchanged.
  - misalign_trap pulses high for exactly one cycle, registered, the cycle after take.
- Undefined:
  - tgt[1] is also forced to 0 (word alignment).
  - misalign_trap is constant 0.

Decomposition:
- Package pc_fetch_pkg:
  - XLEN, RESET_PC default, INSTR_BYTES=4.
  - Enum fetch_state_t {F_BOOT, F_RUN, F_HOLD}.
- Sub-module pc_target_sel (combinational): jalr/branch target select, bit clearing, misalignment detection.
- The top level holds the state register, PC register, pending-redirect buffer, and flush/trap registers.

Test Plan:
- Reset release, RESET_PC=0, ready=1 -> cycle 1 imem_req_valid=1, addr 0; then 4, 8, 12 on consecutive cycles; flush=0.
- pc=0x20, ready=0 for 3 cycles -> imem_addr stays 0x20 and state is F_HOLD; ready=1 -> next addr 0x24.
- pc=0x40, take with branch_target=0x100, ready=1 -> next addr 0x100; flush high exactly one cycle.
- pc=0x40, ready=0, take with jalr=1, jalr_target=0x203 -> pend_target=0x200 and flush stays high; ready=1 -> addr goes 0x40 then 0x200; flush drops the cycle after.
- pc=32'hFFFF_FFFC with ready=1 -> next addr 0; rst mid-pending -> pc=RESET_PC, pend_valid=0, imem_req_valid=0.
- With PC_MISALIGN_TRAP_EN: take with branch_target=0x102 -> misalign_trap pulses one cycle and pc continues to pc+4. Without the macro: next addr 0x100.
